// File: rtl/bsg_manycore_drlp_wgt_loader.sv
// Purpose: packs the master tile's 32-bit word stream into the DRLP slaves' wide weight/bias vectors and sequences start/done.
// Latency: last accepted word to dw_wgt_start_o is 2 cycles when all PEs are ready; done_o is combinational with slave_done_i.
// Backpressure: ready_o is high only in LOAD; words offered in any other state are dropped, so upstream must hold them.
module bsg_manycore_drlp_wgt_loader
  #(parameter int data_width_p = 32
   ,parameter int wgt_words_p  = 288
   ,parameter int bias_words_p = 16
   ,parameter int num_slaves_p = 3
   )
  (input  logic                                 clk_i
  ,input  logic                                 reset_i
  ,input  logic                                 v_i
  ,input  logic [data_width_p-1:0]              data_i
  ,output logic                                 ready_o
  ,input  logic [num_slaves_p-1:0]              pe_ready_i
  ,input  logic [num_slaves_p-1:0]              slave_done_i
  ,output logic [data_width_p*wgt_words_p-1:0]  all_wgt_o
  ,output logic [data_width_p*bias_words_p-1:0] all_bias_o
  ,output logic                                 dw_wgt_start_o
  ,output logic                                 done_o
  ,output logic [1:0]                           state_o
  );

  localparam int total_words_lp    = wgt_words_p + bias_words_p;
  localparam int cnt_width_lp      = (total_words_lp > 1) ? $clog2(total_words_lp) : 1;
  localparam int wgt_idx_width_lp  = (wgt_words_p > 1)    ? $clog2(wgt_words_p)    : 1;
  localparam int bias_idx_width_lp = (bias_words_p > 1)   ? $clog2(bias_words_p)   : 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_e;

  state_e                    state_r;
  logic [cnt_width_lp-1:0]   cnt_r;
  logic                      seen_low_r;

  logic [data_width_p-1:0]   wgt_r  [wgt_words_p];
  logic [data_width_p-1:0]   bias_r [bias_words_p];

  logic                         accept;
  logic                         is_wgt;
  logic                         last_word;
  logic                         all_pe_ready;
  logic                         all_done;
  logic [wgt_idx_width_lp-1:0]  wgt_idx;
  logic [bias_idx_width_lp-1:0] bias_idx;

  assign ready_o        = (state_r == LOAD);
  assign accept         = v_i & ready_o;
  assign all_pe_ready   = &pe_ready_i;
  assign all_done       = &slave_done_i;

  // The word counter selects the slot: the first wgt_words_p words are weights, the rest biases.
  assign is_wgt    = (cnt_r < cnt_width_lp'(wgt_words_p));
  assign last_word = (cnt_r == cnt_width_lp'(total_words_lp - 1));
  assign wgt_idx   = wgt_idx_width_lp'(cnt_r);
  assign bias_idx  = bias_idx_width_lp'(cnt_r - cnt_width_lp'(wgt_words_p));

  assign dw_wgt_start_o = (state_r == START);
  // A done level already high when the run started is not trusted; it must have dropped once in RUN.
  assign done_o         = (state_r == RUN) & seen_low_r & all_done;
  assign state_o        = state_r;

  // Sequence load -> wait for all PEs -> one-cycle start -> run until a fresh done.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= LOAD;
      cnt_r      <= '0;
      seen_low_r <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          if (accept) begin
            if (last_word) begin
              cnt_r   <= '0;
              state_r <= WAIT;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        WAIT: begin
          if (all_pe_ready) state_r <= START;
        end
        START: begin
          seen_low_r <= 1'b0;
          state_r    <= RUN;
        end
        RUN: begin
          if (!all_done) seen_low_r <= 1'b1;
          if (done_o)    state_r    <= LOAD;
        end
        default: state_r <= LOAD;
      endcase
    end
  end

  // Write each accepted word into its weight or bias slot; everything else holds until rewritten.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < wgt_words_p; k++)  wgt_r[k]  <= '0;
      for (int j = 0; j < bias_words_p; j++) bias_r[j] <= '0;
    end else if (accept) begin
      if (is_wgt) wgt_r[wgt_idx]   <= data_i;
      else        bias_r[bias_idx] <= data_i;
    end
  end

  for (genvar k = 0; k < wgt_words_p; k++) begin : g_wgt
    assign all_wgt_o[k*data_width_p +: data_width_p] = wgt_r[k];
  end

  for (genvar j = 0; j < bias_words_p; j++) begin : g_bias
    assign all_bias_o[j*data_width_p +: data_width_p] = bias_r[j];
  end

endmodule

// File: tb/tb_bsg_manycore_drlp_wgt_loader.sv
// Bench for the DRLP weight loader: randomized loads checked against an array model.
// Expected vectors and event cycles are queued by the stimulus and popped by a monitor.
// The monitor fires on WAIT entry, on the start strobe and on the done pulse.
module tb_bsg_manycore_drlp_wgt_loader;

  localparam int DW    = 32;
  localparam int WGT   = 288;
  localparam int BIAS  = 16;
  localparam int NS    = 3;
  localparam int TOTAL = WGT + BIAS;
  localparam int WB    = DW * WGT;
  localparam int BB    = DW * BIAS;

  logic            clk = 1'b0;
  logic            reset_i;
  logic            v_i;
  logic [DW-1:0]   data_i;
  logic            ready_o;
  logic [NS-1:0]   pe_ready_i;
  logic [NS-1:0]   slave_done_i;
  logic [WB-1:0]   all_wgt_o;
  logic [BB-1:0]   all_bias_o;
  logic            dw_wgt_start_o;
  logic            done_o;
  logic [1:0]      state_o;

  bsg_manycore_drlp_wgt_loader #(
    .data_width_p (DW),
    .wgt_words_p  (WGT),
    .bias_words_p (BIAS),
    .num_slaves_p (NS)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .v_i            (v_i),
    .data_i         (data_i),
    .ready_o        (ready_o),
    .pe_ready_i     (pe_ready_i),
    .slave_done_i   (slave_done_i),
    .all_wgt_o      (all_wgt_o),
    .all_bias_o     (all_bias_o),
    .dw_wgt_start_o (dw_wgt_start_o),
    .done_o         (done_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: word n of a load lands at weight n, or bias n-WGT.
  logic [WB-1:0] mdl_wgt;
  logic [BB-1:0] mdl_bias;

  logic [WB-1:0] exp_wgt_q  [$];
  logic [BB-1:0] exp_bias_q [$];
  int            exp_start_q[$];
  int            exp_done_q [$];

  logic [WB-1:0] ew;
  logic [BB-1:0] eb;
  logic [1:0]    prev_state = 2'd0;
  int            n_cycles;
  int            last_acc;
  int            exp_c;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk_vec(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp, input int nw);
    int bad;
    bad = -1;
    n_chk++;
    for (int k = 0; k < nw; k++) begin
      if (act[k*DW +: DW] !== exp[k*DW +: DW]) begin
        bad = k;
        break;
      end
    end
    if (bad < 0) n_pass++;
    else $display("FAIL %s: word %0d got 0x%0h expected 0x%0h (cycle %0d)",
                  nm, bad, act[bad*DW +: DW], exp[bad*DW +: DW], cyc);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", nm, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer words first..last-1 of a load with value base+index; gaps drive junk data with v_i low.
  task automatic load_words(input int base, input bit gaps, input int first, input int last,
                            output int cycles, output int lacc);
    int i;
    i = first;
    cycles = 0;
    lacc = -1;
    while (i < last && cycles < 4000) begin
      v_i    = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      data_i = v_i ? DW'(base + i) : $urandom();
      @(negedge clk);
      if (v_i && ready_o) begin
        if (i < WGT) mdl_wgt[i*DW +: DW] = DW'(base + i);
        else         mdl_bias[(i-WGT)*DW +: DW] = DW'(base + i);
        lacc = cyc;
        i++;
      end
      cycles++;
      step();
    end
    v_i    = 1'b0;
    data_i = $urandom();
    if (i < last) fail("load_timeout");
    if (i == TOTAL) begin
      exp_wgt_q.push_back(mdl_wgt);
      exp_bias_q.push_back(mdl_bias);
    end
  endtask

  // Drive one run: start either as soon as possible (PEs already ready) or after a partial-ready spell,
  // then hold a stale done, drop it for one cycle and raise it again.
  task automatic do_run(input bit ready_early, input int lacc);
    int s;
    slave_done_i = '1;
    v_i          = 1'b1;
    data_i       = $urandom();
    if (ready_early) begin
      s = lacc + 2;
    end else begin
      pe_ready_i = 3'b011;
      repeat (10) begin
        step();
        data_i = $urandom();
      end
      pe_ready_i = 3'b111;
      s = cyc + 1;
    end
    exp_start_q.push_back(s);
    while (cyc < s + 1) step();
    @(negedge clk);
    chk("run_state", 64'(state_o), 64'd3);
    step();
    repeat (6) begin
      step();
      data_i = $urandom();
    end
    v_i          = 1'b0;
    slave_done_i = '0;
    step();
    slave_done_i = '1;
    exp_done_q.push_back(cyc);
    step();
    @(negedge clk);
    chk("ready_after_done", 64'(ready_o), 64'd1);
    chk("state_after_done", 64'(state_o), 64'd0);
    step();
    pe_ready_i   = '0;
    slave_done_i = '0;
  endtask

  // Monitor: pops the expected record whenever the DUT presents a WAIT entry, a start strobe or a done pulse.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (state_o == 2'd1 && prev_state != 2'd1) begin
        if (exp_wgt_q.size() == 0) fail("unexpected_wait");
        else begin
          ew = exp_wgt_q.pop_front();
          eb = exp_bias_q.pop_front();
          chk_vec("wait_wgt", all_wgt_o, ew, WGT);
          chk_vec("wait_bias", WB'(all_bias_o), WB'(eb), BIAS);
        end
      end
      if (dw_wgt_start_o) begin
        if (exp_start_q.size() == 0) fail("unexpected_start");
        else begin
          exp_c = exp_start_q.pop_front();
          chk("start_cycle", 64'(cyc), 64'(exp_c));
          chk_vec("start_wgt", all_wgt_o, mdl_wgt, WGT);
        end
      end
      if (done_o) begin
        if (exp_done_q.size() == 0) fail("unexpected_done");
        else begin
          exp_c = exp_done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(exp_c));
          chk_vec("done_wgt", all_wgt_o, mdl_wgt, WGT);
          chk_vec("done_bias", WB'(all_bias_o), WB'(mdl_bias), BIAS);
        end
      end
    end
    prev_state = state_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset_i      = 1'b1;
    v_i          = 1'b0;
    data_i       = '0;
    pe_ready_i   = '0;
    slave_done_i = '0;
    mdl_wgt      = '0;
    mdl_bias     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;

    // Reset values, first cycle out of reset.
    @(negedge clk);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_start", 64'(dw_wgt_start_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk_vec("rst_wgt", all_wgt_o, '0, WGT);
    chk_vec("rst_bias", WB'(all_bias_o), '0, BIAS);
    step();

    // Gap-free load of 0x1000+i, then a run with a partial-ready spell.
    load_words(32'h1000, 1'b0, 0, TOTAL, n_cycles, last_acc);
    chk("load_ready_cycles", 64'(n_cycles), 64'(TOTAL));
    @(negedge clk);
    chk("post_load_state", 64'(state_o), 64'd1);
    chk("post_load_ready", 64'(ready_o), 64'd0);
    chk("wgt_word0", 64'(all_wgt_o[0 +: DW]), 64'h1000);
    chk("wgt_word287", 64'(all_wgt_o[287*DW +: DW]), 64'h111F);
    chk("bias_word0", 64'(all_bias_o[0 +: DW]), 64'h1120);
    chk("bias_word15", 64'(all_bias_o[15*DW +: DW]), 64'h112F);
    step();
    do_run(1'b0, last_acc);

    // Second load of 0xA000+i with PEs already ready; old biases hold until rewritten.
    pe_ready_i = '1;
    load_words(32'hA000, 1'b0, 0, 290, n_cycles, last_acc);
    @(negedge clk);
    chk("part_state", 64'(state_o), 64'd0);
    chk("part_wgt0", 64'(all_wgt_o[0 +: DW]), 64'hA000);
    chk("part_bias0", 64'(all_bias_o[0 +: DW]), 64'hA120);
    chk("part_bias1", 64'(all_bias_o[1*DW +: DW]), 64'hA121);
    chk("part_bias2_old", 64'(all_bias_o[2*DW +: DW]), 64'h1122);
    chk("part_bias15_old", 64'(all_bias_o[15*DW +: DW]), 64'h112F);
    step();
    load_words(32'hA000, 1'b0, 290, TOTAL, n_cycles, last_acc);
    do_run(1'b1, last_acc);

    // Load with random v_i gaps and junk data in the gaps.
    load_words(32'h1000, 1'b1, 0, TOTAL, n_cycles, last_acc);
    do_run(1'b0, last_acc);

    // Reset after 100 words, then a fresh gapped load from word 0.
    load_words(32'h3000, 1'b0, 0, 100, n_cycles, last_acc);
    reset_i = 1'b1;
    step();
    reset_i  = 1'b0;
    mdl_wgt  = '0;
    mdl_bias = '0;
    @(negedge clk);
    chk("midrst_state", 64'(state_o), 64'd0);
    chk("midrst_ready", 64'(ready_o), 64'd1);
    chk_vec("midrst_wgt", all_wgt_o, '0, WGT);
    chk_vec("midrst_bias", WB'(all_bias_o), '0, BIAS);
    step();
    load_words(32'h7000, 1'b1, 0, TOTAL, n_cycles, last_acc);
    do_run(1'b0, last_acc);

    repeat (4) step();
    chk("pending_wait", 64'(exp_wgt_q.size()), 64'd0);
    chk("pending_start", 64'(exp_start_q.size()), 64'd0);
    chk("pending_done", 64'(exp_done_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
